// File: rtl/mul_iter_pkg.sv
// mul_iter_pkg: shared widths, FSM states and operand magnitude helper for mul_iter
package mul_iter_pkg;
  localparam int DATA_W = 32;
  localparam int CNT_W = 5;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v, input logic s);
    return (s && v[DATA_W-1]) ? -v : v;
  endfunction
endpackage

// File: rtl/mul_iter_if.sv
// mul_iter_if: operand request, pipeline control and regfile write bundle of mul_iter
interface mul_iter_if;
  import mul_iter_pkg::*;
  logic start;
  logic is_signed;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;
  logic annul;
  logic stall;
  logic busy;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic mul_we;
  modport master (output start, is_signed, op1, op2, annul, input stall, busy, hi, lo, mul_we);
  modport slave (input start, is_signed, op1, op2, annul, output stall, busy, hi, lo, mul_we);
endinterface

// File: rtl/mul_iter.sv
// mul_iter: radix-2 shift-add 32x32 MULT/MULTU engine with stall request and one-cycle hi/lo write strobe
module mul_iter
  import mul_iter_pkg::*;
(
  input logic clk,
  input logic rst,
  mul_iter_if.slave bus
);
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [DATA_W-1:0] mcand;
  logic [2*DATA_W-1:0] acc, acc_nx, prod;
  logic [DATA_W:0] sum;
  logic neg, accept, zero_op, last;
  always_comb begin
    accept = state == IDLE && bus.start && !bus.annul;
    zero_op = bus.op1 == '0 || bus.op2 == '0;
    last = cnt == CNT_W'(DATA_W - 1);
    sum = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, mcand} : '0);
    acc_nx = {sum, acc[DATA_W-1:1]};
    prod = neg ? -acc_nx : acc_nx;
    state_nx = state == IDLE ? (accept ? (zero_op ? DONE : RUN) : IDLE)
             : state == RUN ? (bus.annul ? IDLE : last ? DONE : RUN)
             : IDLE;
    bus.stall = accept || state == RUN;
    bus.busy = state != IDLE;
    bus.mul_we = state == DONE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      acc <= '0;
      mcand <= '0;
      neg <= 1'b0;
      bus.hi <= '0;
      bus.lo <= '0;
    end else if (accept) begin
      cnt <= '0;
      mcand <= mag(bus.op1, bus.is_signed);
      acc <= {{DATA_W{1'b0}}, mag(bus.op2, bus.is_signed)};
      neg <= bus.is_signed && (bus.op1[DATA_W-1] ^ bus.op2[DATA_W-1]);
      if (zero_op) begin
        bus.hi <= '0;
        bus.lo <= '0;
      end
    end else if (state == RUN && !bus.annul) begin
      cnt <= cnt + 1'b1;
      acc <= acc_nx;
      if (last) begin
        bus.hi <= prod[2*DATA_W-1:DATA_W];
        bus.lo <= prod[DATA_W-1:0];
      end
    end
  end
endmodule
